// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipeline.
// Drives latch load enables, bubble controls and two perf counters.
module pipeline_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_load,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 dmem_resp,
    input  logic                 br_taken,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic {
        RUN,
        DISCARD
    } state_t;

    state_t state, state_n;
    logic   dmem_busy;
    logic   imem_busy;
    logic   redirect;
    logic   bubble;

    assign dmem_busy = (dmem_read | dmem_write) & ~dmem_resp;
    assign imem_busy = imem_read & ~imem_resp;

    always_comb begin
        state_n      = state;
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        redirect     = 1'b0;
        if (reset) begin
            state_n      = RUN;
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            load_id_ex   = 1'b0;
            load_ex_mem  = 1'b0;
            load_mem_wb  = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (dmem_busy) begin
                        load_pc     = 1'b0;
                        load_if_id  = 1'b0;
                        load_id_ex  = 1'b0;
                        load_ex_mem = 1'b0;
                        load_mem_wb = 1'b0;
                    end else if (br_taken) begin
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        redirect     = 1'b1;
                        // An in-flight fetch is wrong-path; drop it when it lands
                        if (imem_busy)
                            state_n = DISCARD;
                    end else if (stall_load) begin
                        load_pc     = 1'b0;
                        load_if_id  = 1'b0;
                        flush_id_ex = 1'b1;
                    end else if (imem_busy) begin
                        load_pc     = 1'b0;
                        flush_if_id = 1'b1;
                    end
                end
                DISCARD: begin
                    load_pc     = 1'b0;
                    flush_if_id = 1'b1;
                    if (dmem_busy) begin
                        load_if_id  = 1'b0;
                        load_id_ex  = 1'b0;
                        load_ex_mem = 1'b0;
                        load_mem_wb = 1'b0;
                    end
                    if (imem_resp)
                        state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign bubble = ~(load_pc & load_if_id & load_id_ex & load_ex_mem & load_mem_wb)
                  | (load_if_id & flush_if_id);

    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (bubble && !(&stall_count))
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (redirect && !(&flush_count))
                flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl.
// Checks a 16-bit and a 4-bit counter instance side by side.
module tb_pipeline_ctrl;

    logic clk;
    logic reset;
    logic stall_load, imem_read, imem_resp;
    logic dmem_read, dmem_write, dmem_resp, br_taken;

    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [15:0] stall_count, flush_count;

    logic        s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
    logic        s_flush_if_id, s_flush_id_ex, s_flush_ex_mem;
    logic [3:0]  s_stall_count, s_flush_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  ld;
        logic [2:0]  fl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];

    pipeline_ctrl #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .stall_load(stall_load), .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .br_taken(br_taken),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .stall_load(stall_load), .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .br_taken(br_taken),
        .load_pc(s_load_pc), .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex),
        .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .flush_ex_mem(s_flush_ex_mem),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sat4(input logic [15:0] v);
        return (v > 16'd15) ? 16'd15 : v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s %s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    // in = {reset, stall_load, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, br_taken}
    // ld = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem}
    // sc/fc are the counter values visible during this cycle
    task automatic step(input string tag, input logic [7:0] in,
                        input logic [4:0] ld, input logic [2:0] fl,
                        input int sc, input int fc);
        exp_t e;
        {reset, stall_load, imem_read, imem_resp,
         dmem_read, dmem_write, dmem_resp, br_taken} = in;
        e.ld = ld;
        e.fl = fl;
        e.sc = 16'(sc);
        e.fc = 16'(fc);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk(tag, "loads", {11'b0, load_pc, load_if_id, load_id_ex,
                           load_ex_mem, load_mem_wb}, {11'b0, e.ld});
        chk(tag, "flushes", {13'b0, flush_if_id, flush_id_ex, flush_ex_mem},
            {13'b0, e.fl});
        chk(tag, "stall_count", stall_count, e.sc);
        chk(tag, "flush_count", flush_count, e.fc);
        chk(tag, "stall_count4", {12'b0, s_stall_count}, sat4(e.sc));
        chk(tag, "flush_count4", {12'b0, s_flush_count}, sat4(e.fc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        {reset, stall_load, imem_read, imem_resp,
         dmem_read, dmem_write, dmem_resp, br_taken} = 8'b1000_0000;
        @(posedge clk);
        #1;
        step("reset",        8'b1000_0000, 5'b00000, 3'b111, 0, 0);
        step("idle",         8'b0000_0000, 5'b11111, 3'b000, 0, 0);
        step("load_use",     8'b0100_0000, 5'b00111, 3'b010, 0, 0);
        step("after_stall",  8'b0000_0000, 5'b11111, 3'b000, 1, 0);
        step("dfrz1",        8'b0000_1000, 5'b00000, 3'b000, 1, 0);
        step("dfrz2_stall",  8'b0100_1000, 5'b00000, 3'b000, 2, 0);
        step("dfrz3_br",     8'b0000_1001, 5'b00000, 3'b000, 3, 0);
        step("dresp",        8'b0000_1010, 5'b11111, 3'b000, 4, 0);
        step("idle2",        8'b0000_0000, 5'b11111, 3'b000, 4, 0);
        step("br_imiss",     8'b0010_0001, 5'b11111, 3'b111, 4, 0);
        step("discard1",     8'b0010_0000, 5'b01111, 3'b100, 5, 1);
        step("discard2",     8'b0010_0000, 5'b01111, 3'b100, 6, 1);
        step("discard_resp", 8'b0011_0000, 5'b01111, 3'b100, 7, 1);
        step("back_run",     8'b0000_0000, 5'b11111, 3'b000, 8, 1);
        step("br_with_resp", 8'b0011_0001, 5'b11111, 3'b111, 8, 1);
        step("no_discard",   8'b0000_0000, 5'b11111, 3'b000, 9, 2);
        step("imiss",        8'b0010_0000, 5'b01111, 3'b100, 9, 2);
        step("br_imiss2",    8'b0010_0001, 5'b11111, 3'b111, 10, 2);
        step("disc_dfrz",    8'b0011_1000, 5'b00000, 3'b100, 11, 3);
        step("resp_dropped", 8'b0000_0000, 5'b11111, 3'b000, 12, 3);
        step("br_imiss3",    8'b0010_0001, 5'b11111, 3'b111, 12, 3);
        step("reset_disc",   8'b1010_0000, 5'b00000, 3'b111, 13, 4);
        step("stale_resp",   8'b0011_0000, 5'b11111, 3'b000, 0, 0);
        for (int i = 0; i < 20; i++)
            step("sat_stall", 8'b0100_0000, 5'b00111, 3'b010, i, 0);
        step("sat_done",     8'b0000_0000, 5'b11111, 3'b000, 20, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
